// File: rtl/gray_mul_sched.sv
// Shares one start/done FP32 multiplier across the R, G, B weights of the gray path.
// Optional build macro ZERO_SKIP_EN: zero channels bypass the multiplier entirely.
module gray_mul_sched #(
  parameter logic [31:0] RED_FACTOR   = 32'h3e991687,
  parameter logic [31:0] GREEN_FACTOR = 32'h3f1645a2,
  parameter logic [31:0] BLUE_FACTOR  = 32'h3de978d5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  input  logic [31:0] Red_In,
  input  logic [31:0] Green_In,
  input  logic [31:0] Blue_In,
  output logic        MUL_START,
  output logic [31:0] MUL_A,
  output logic [31:0] MUL_B,
  input  logic [31:0] MUL_RESULT,
  input  logic        MUL_DONE,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] Red_Out,
  output logic [31:0] Green_Out,
  output logic [31:0] Blue_Out,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t          state_q;
  logic [1:0]      ch_q;
  logic [2:0][31:0] pix_q;
  logic [2:0][31:0] prod_q;
  logic            rdy_q, start_q, ovld_q;
  logic [31:0]     a_q, b_q;

  logic [1:0]  nch;
  logic [31:0] nval, cval;
  logic        nxt_start, cur_zero;

  function automatic logic [31:0] factor(input logic [1:0] c);
    case (c)
      2'd0:    return RED_FACTOR;
      2'd1:    return GREEN_FACTOR;
      default: return BLUE_FACTOR;
    endcase
  endfunction

  function automatic logic [31:0] chan_sel(input logic [2:0][31:0] p, input logic [1:0] c);
    case (c)
      2'd0:    return p[0];
      2'd1:    return p[1];
      default: return p[2];
    endcase
  endfunction

  // Channel/value the next ISSUE will use: R straight from the inputs on accept.
  assign nch      = (state_q == IDLE) ? 2'd0 : ch_q + 2'd1;
  assign nval     = (state_q == IDLE) ? Red_In : chan_sel(pix_q, nch);
  assign cval     = chan_sel(pix_q, ch_q);
  assign cur_zero = (cval == 32'h0);

`ifdef ZERO_SKIP_EN
  assign nxt_start = (nval != 32'h0);
`else
  assign nxt_start = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      pix_q   <= '0;
      prod_q  <= '0;
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      ovld_q  <= 1'b0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (PIX_VALID && rdy_q) begin
            pix_q   <= {Blue_In, Green_In, Red_In};
            ch_q    <= 2'd0;
            rdy_q   <= 1'b0;
            state_q <= ISSUE;
            start_q <= nxt_start;
            a_q     <= nval;
            b_q     <= factor(nch);
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
`ifdef ZERO_SKIP_EN
          if (cur_zero) begin
            for (int i = 0; i < 3; i++)
              if (ch_q == 2'(i)) prod_q[i] <= 32'h0;
            if (ch_q == 2'd2) begin
              state_q <= OUT;
              ovld_q  <= 1'b1;
            end else begin
              ch_q    <= nch;
              start_q <= nxt_start;
              a_q     <= nval;
              b_q     <= factor(nch);
            end
          end else begin
            state_q <= WAIT;
          end
`else
          state_q <= WAIT;
`endif
        end
        WAIT: begin
          if (MUL_DONE) begin
            // Exact +0.0 inputs force a zero product whatever the multiplier says.
            for (int i = 0; i < 3; i++)
              if (ch_q == 2'(i)) prod_q[i] <= cur_zero ? 32'h0 : MUL_RESULT;
            if (ch_q == 2'd2) begin
              state_q <= OUT;
              ovld_q  <= 1'b1;
            end else begin
              ch_q    <= nch;
              state_q <= ISSUE;
              start_q <= nxt_start;
              a_q     <= nval;
              b_q     <= factor(nch);
            end
          end
        end
        OUT: begin
          if (OUT_READY) begin
            ovld_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PIX_READY = rdy_q;
  assign MUL_START = start_q;
  assign MUL_A     = a_q;
  assign MUL_B     = b_q;
  assign OUT_VALID = ovld_q;
  assign Red_Out   = prod_q[0];
  assign Green_Out = prod_q[1];
  assign Blue_Out  = prod_q[2];
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_gray_mul_sched.sv
// Bench for gray_mul_sched: latency-L stub multiplier, vector table, scoreboard on the output handshake.
module tb_gray_mul_sched;

  localparam int L = 2;
  localparam logic [31:0] ONE = 32'h3f800000;
  localparam logic [31:0] RF = 32'h3e991687, GF = 32'h3f1645a2, BF = 32'h3de978d5;
`ifdef ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic CLK, RST, PIX_VALID, PIX_READY, MUL_START, MUL_DONE, OUT_VALID, OUT_READY, BUSY;
  logic [31:0] Red_In, Green_In, Blue_In, MUL_A, MUL_B, MUL_RESULT, Red_Out, Green_Out, Blue_Out;

  gray_mul_sched dut (
    .CLK(CLK), .RST(RST), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .Red_In(Red_In), .Green_In(Green_In), .Blue_In(Blue_In),
    .MUL_START(MUL_START), .MUL_A(MUL_A), .MUL_B(MUL_B),
    .MUL_RESULT(MUL_RESULT), .MUL_DONE(MUL_DONE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Red_Out(Red_Out), .Green_Out(Green_Out), .Blue_Out(Blue_Out), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0, fails = 0, cyc = 0, starts = 0, cnt = 0;
  logic bad = 1'b0, inj = 1'b0;
  logic [31:0] res_q = 32'h0;
  logic [31:0] mulb_q[$];
  logic [95:0] exp_q[$];
  logic [95:0] e;

  // Stub multiplier: 1.0*B returns B exactly, otherwise A^B as a traceable pseudo-product.
  function automatic logic [31:0] stub_fn(input logic [31:0] a, input logic [31:0] b);
    return (a == ONE) ? b : (a ^ b);
  endfunction

  function automatic logic [31:0] fac(input int c);
    return (c == 0) ? RF : (c == 1) ? GF : BF;
  endfunction

  function automatic logic [95:0] model(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    logic [31:0] p [3];
    logic [31:0] v [3];
    v = '{r, g, b};
    for (int c = 0; c < 3; c++) p[c] = (v[c] == 32'h0) ? 32'h0 : stub_fn(v[c], fac(c));
    return {p[0], p[1], p[2]};
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (MUL_START) begin
      cnt   <= L;
      res_q <= bad ? 32'hdeadbeef : stub_fn(MUL_A, MUL_B);
    end else if (cnt != 0) cnt <= cnt - 1;
  end
  assign MUL_DONE   = (cnt == 1) || inj;
  assign MUL_RESULT = inj ? 32'hdeadbeef : res_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (MUL_START) begin
      starts++;
      mulb_q.push_back(MUL_B);
    end
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) check("sb_unexpected_output", 32'h1, 32'h0);
      else begin
        e = exp_q.pop_front();
        check("sb_red",   Red_Out,   e[95:64]);
        check("sb_green", Green_Out, e[63:32]);
        check("sb_blue",  Blue_Out,  e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!PIX_READY && g < 50) begin tick(); g++; end
    check("pix_ready_timeout", PIX_READY, 1'b1);
  endtask

  typedef struct packed {
    logic [31:0] r, g, b;
    logic        bad;
    logic [31:0] er, eg, eb;
  } vec_t;

  task automatic run_vec(input vec_t v, input int stall, input bit inj_issue);
    int n, k, lat, s0;
    logic [31:0] ch [3];
    logic [31:0] hold;
    ch = '{v.r, v.g, v.b};
    wait_ready();
    Red_In = v.r; Green_In = v.g; Blue_In = v.b; bad = v.bad;
    PIX_VALID = 1'b1;
    exp_q.push_back({v.er, v.eg, v.eb});
    starts = 0;
    mulb_q.delete();
    tick();
    PIX_VALID = 1'b0;
    n = 1;
    if (inj_issue) begin
      hold = Red_Out;
      inj = 1'b1;
      tick(); n++;
      inj = 1'b0;
      check("issue_done_red_held", Red_Out, hold);
      check("issue_done_busy", BUSY, 1'b1);
      check("issue_done_out_valid", OUT_VALID, 1'b0);
    end
    while (!OUT_VALID && n < 200) begin tick(); n++; end
    lat = 1;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      if (ZSKIP && ch[c] == 32'h0) lat += 1;
      else begin
        lat += L + 1;
        if (k < mulb_q.size()) check("mul_b_order", mulb_q[k], fac(c));
        k++;
      end
    end
    check("out_latency", n, lat);
    check("mul_start_count", starts, k);
    s0 = starts;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_out_valid", OUT_VALID, 1'b1);
      check("stall_red", Red_Out, v.er);
      check("stall_blue", Blue_Out, v.eb);
      check("stall_pix_ready", PIX_READY, 1'b0);
      check("stall_no_start", starts, s0);
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("post_hs_out_valid", OUT_VALID, 1'b0);
    check("post_hs_pix_ready", PIX_READY, 1'b1);
    check("post_hs_green_kept", Green_Out, v.eg);
    bad = 1'b0;
  endtask

  vec_t vt [5];
  logic [31:0] pr [3], pg [3], pb [3];

  initial begin
    vt[0] = '{ONE, ONE, ONE, 1'b0, RF, GF, BF};
    vt[1] = '{ONE, 32'h0, ONE, 1'b1, 32'hdeadbeef, 32'h0, 32'hdeadbeef};
    vt[2] = '{32'h40000000, 32'h80000000, 32'h0, 1'b0, 32'h7e991687, 32'hbf1645a2, 32'h0};
    vt[3] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    vt[4] = '{32'h3f000000, 32'h3fc00000, 32'h40400000, 1'b0, 32'h01991687, 32'h00d645a2, 32'h7da978d5};

    RST = 1'b1; PIX_VALID = 1'b0; OUT_READY = 1'b0;
    Red_In = 32'h0; Green_In = 32'h0; Blue_In = 32'h0;
    repeat (3) tick();
    check("rst_pix_ready", PIX_READY, 1'b0);
    check("rst_mul_start", MUL_START, 1'b0);
    check("rst_out_valid", OUT_VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_mul_a", MUL_A, 32'h0);
    check("rst_mul_b", MUL_B, 32'h0);
    check("rst_red", Red_Out, 32'h0);
    check("rst_green", Green_Out, 32'h0);
    check("rst_blue", Blue_Out, 32'h0);
    RST = 1'b0;
    tick();
    check("first_pix_ready", PIX_READY, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(vt[i], (i == 0) ? 5 : 0, i == 4);

    // Stray MUL_DONE while idle must not touch products or state.
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("idle_done_red", Red_Out, vt[4].er);
    check("idle_done_blue", Blue_Out, vt[4].eb);
    check("idle_done_busy", BUSY, 1'b0);
    check("idle_done_ready", PIX_READY, 1'b1);

    // Reset during channel-1 WAIT; the stub's done arrives the cycle after.
    Red_In = ONE; Green_In = ONE; Blue_In = ONE; PIX_VALID = 1'b1;
    tick();
    PIX_VALID = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", BUSY, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_mid_mul_start", MUL_START, 1'b0);
    check("rst_mid_busy", BUSY, 1'b0);
    check("rst_mid_red", Red_Out, 32'h0);
    check("rst_mid_out_valid", OUT_VALID, 1'b0);
    check("late_done_seen", MUL_DONE, 1'b1);
    tick();
    check("rst_mid_ready", PIX_READY, 1'b1);
    check("late_done_red", Red_Out, 32'h0);
    check("late_done_busy", BUSY, 1'b0);
    run_vec(vt[0], 0, 1'b0);

    // Back-to-back pixels, both handshakes held open.
    pr = '{ONE, 32'h40000000, 32'h3fc00000};
    pg = '{ONE, 32'h3f000000, 32'h40800000};
    pb = '{ONE, 32'h40400000, ONE};
    begin
      int k = 0, last = 0, g = 0;
      bit acc;
      OUT_READY = 1'b1;
      PIX_VALID = 1'b1;
      Red_In = pr[0]; Green_In = pg[0]; Blue_In = pb[0];
      while (k < 3 && g < 200) begin
        acc = PIX_READY;
        if (acc) begin
          exp_q.push_back(model(pr[k], pg[k], pb[k]));
          if (k > 0) check("b2b_period", cyc - last, 3 * L + 5);
          last = cyc;
        end
        tick(); g++;
        if (acc) begin
          k++;
          if (k < 3) begin Red_In = pr[k]; Green_In = pg[k]; Blue_In = pb[k]; end
        end
      end
      check("b2b_accepted", k, 3);
      PIX_VALID = 1'b0;
      g = 0;
      while (exp_q.size() != 0 && g < 100) begin tick(); g++; end
      check("b2b_drained", exp_q.size(), 0);
      OUT_READY = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
